// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO controller.
// Optional debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
package gpio_pkg;

  localparam logic IT_LEVEL = 1'b0;
  localparam logic IT_EDGE  = 1'b1;
  localparam logic IP_LOW   = 1'b0;
  localparam logic IP_HIGH  = 1'b1;

  localparam int unsigned GPIO_NPINS_DEF = 16;
  localparam int unsigned DB_CNT_W       = 8;

`ifdef GPIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

endpackage

// File: rtl/gpio_ctrl_if.sv
// Wrapper-side GPIO register bus; master = register wrapper, slave = gpio_ctrl.
interface gpio_ctrl_if import gpio_pkg::*; #(
  parameter int unsigned NPINS = GPIO_NPINS_DEF
);

  logic [NPINS-1:0] WGPIODIN;
  logic [NPINS-1:0] WGPIODOUT;
  logic [NPINS-1:0] WGPIOPU;
  logic [NPINS-1:0] WGPIOPD;
  logic [NPINS-1:0] WGPIODIR;
  logic [NPINS-1:0] WGPIOIE;
  logic [NPINS-1:0] WGPIOIT;
  logic [NPINS-1:0] WGPIOIP;
  logic [NPINS-1:0] WGPIOIC;
  logic [NPINS-1:0] WGPIOIS;

  modport master (
    input  WGPIODIN, WGPIOIS,
    output WGPIODOUT, WGPIOPU, WGPIOPD, WGPIODIR,
    output WGPIOIE, WGPIOIT, WGPIOIP, WGPIOIC
  );

  modport slave (
    output WGPIODIN, WGPIOIS,
    input  WGPIODOUT, WGPIOPU, WGPIOPD, WGPIODIR,
    input  WGPIOIE, WGPIOIT, WGPIOIP, WGPIOIC
  );

endinterface

// File: rtl/gpio_ctrl_in_bit.sv
// One-pin input path: synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detect.
module gpio_in_bit import gpio_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic f_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f;
  logic                   p_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (DB_EN && DB_CYCLES > 1) begin : g_db
    logic                f_q, f_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while s disagrees with f; any return to f reloads it.
    always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (s != f_q) begin
        if (cnt_q == DB_CNT_W'(DB_CYCLES - 1)) f_d = s;
        else                                   cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        f_q   <= 1'b0;
        cnt_q <= '0;
      end else begin
        f_q   <= f_d;
        cnt_q <= cnt_d;
      end
    end

    assign f = f_q;
  end else begin : g_nodb
    assign f = s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) p_q <= 1'b0;
    else       p_q <= f;
  end

  assign f_o    = f;
  assign rise_o = f & ~p_q;
  assign fall_o = ~f & p_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: pad passthrough, synchronised inputs, sticky per-pin IRQ status.
// Defining GPIO_DEBOUNCE_EN inserts a DB_CYCLES stability filter on every input.
module gpio_ctrl import gpio_pkg::*; #(
  parameter int unsigned NPINS       = GPIO_NPINS_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  gpio_ctrl_if.slave       w,
  output logic             IRQ,
  input  logic [NPINS-1:0] GPIOIN,
  output logic [NPINS-1:0] GPIOOUT,
  output logic [NPINS-1:0] GPIOPU,
  output logic [NPINS-1:0] GPIOPD,
  output logic [NPINS-1:0] GPIOOEN
);

  localparam int unsigned ARM_CNT = SYNC_STAGES + 1 + (DB_EN ? DB_CYCLES : 0);
  localparam int unsigned ARM_W   = $clog2(ARM_CNT + 1);

  logic [NPINS-1:0] f, rise, fall, evt;
  logic [NPINS-1:0] is_q, is_d;
  logic             irq_q;
  logic [ARM_W-1:0] arm_q;
  logic             armed;

  assign GPIOOUT = w.WGPIODOUT;
  assign GPIOPU  = w.WGPIOPU;
  assign GPIOPD  = w.WGPIOPD;
  assign GPIOOEN = w.WGPIODIR;

  for (genvar g = 0; g < NPINS; g++) begin : g_pin
    gpio_in_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_in (
      .clk_i  (HCLK),
      .rst_i  (HRESET),
      .pin_i  (GPIOIN[g]),
      .f_o    (f[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  // Events stay masked until the input pipeline has flushed its reset values.
  assign armed = (arm_q == ARM_W'(ARM_CNT));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      arm_q <= '0;
    else if (!armed) arm_q <= arm_q + ARM_W'(1);
  end

  always_comb begin
    evt = '0;
    for (int unsigned i = 0; i < NPINS; i++) begin
      if (w.WGPIOIT[i] == IT_EDGE) evt[i] = (w.WGPIOIP[i] == IP_HIGH) ? rise[i] : fall[i];
      else                         evt[i] = (f[i] == w.WGPIOIP[i]);
    end
    if (!armed) evt = '0;
  end

  assign is_d = (is_q & ~w.WGPIOIC) | (evt & w.WGPIOIE);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      is_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      is_q  <= is_d;
      irq_q <= |(is_q & w.WGPIOIE);
    end
  end

  assign w.WGPIODIN = f;
  assign w.WGPIOIS  = is_q;
  assign IRQ        = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed scoreboard bench for gpio_ctrl; covers the GPIO_DEBOUNCE_EN build when defined.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned SS = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned DB = 8;
`else
  localparam int unsigned DB = 0;
`endif
  localparam int unsigned LAT = SS + DB;
  localparam int unsigned ARM = SS + DB + 1;

  localparam int unsigned S_DIN = 0, S_IS = 1, S_IRQ = 2, S_OUT = 3,
                          S_OEN = 4, S_PU = 5, S_PD = 6;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic         IRQ;
  logic [N-1:0] GPIOIN, GPIOOUT, GPIOPU, GPIOPD, GPIOOEN;

  gpio_ctrl_if #(.NPINS(N)) wif ();

  gpio_ctrl #(
    .NPINS       (N),
    .SYNC_STAGES (SS),
    .DB_CYCLES   (8)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .w       (wif),
    .IRQ     (IRQ),
    .GPIOIN  (GPIOIN),
    .GPIOOUT (GPIOOUT),
    .GPIOPU  (GPIOPU),
    .GPIOPD  (GPIOPD),
    .GPIOOEN (GPIOOEN)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      S_DIN:   return 32'(wif.WGPIODIN);
      S_IS:    return 32'(wif.WGPIOIS);
      S_IRQ:   return 32'(IRQ);
      S_OUT:   return 32'(GPIOOUT);
      S_OEN:   return 32'(GPIOOEN);
      S_PU:    return 32'(GPIOPU);
      S_PD:    return 32'(GPIOPD);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int unsigned sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    HRESET         = 1'b1;
    GPIOIN         = '1;
    wif.WGPIODOUT  = '0;
    wif.WGPIOPU    = '0;
    wif.WGPIOPD    = '0;
    wif.WGPIODIR   = '0;
    wif.WGPIOIE    = '1;
    wif.WGPIOIT    = '1;
    wif.WGPIOIP    = '1;
    wif.WGPIOIC    = '0;

    // Reset state and arm suppression of the reset-induced rising edges
    tick(2);
    expect_v("rst_din", S_DIN, 32'h0);
    expect_v("rst_is",  S_IS,  32'h0);
    expect_v("rst_irq", S_IRQ, 32'h0);
    check_out();
    HRESET = 1'b0;
    tick(LAT - 1);
    expect_v("din_pre_lat", S_DIN, 32'h0);
    check_out();
    tick(1);
    expect_v("din_at_lat", S_DIN, 32'hFFFF);
    check_out();
    for (int i = 0; i < 6; i++) begin
      tick(1);
      expect_v("arm_is",  S_IS,  32'h0);
      expect_v("arm_irq", S_IRQ, 32'h0);
      check_out();
    end

    // Pin 3 rising edge, then write-one-to-clear
    wif.WGPIOIE = 16'h0008;
    GPIOIN      = '0;
    tick(LAT + 3);
    expect_v("t2_idle_is",  S_IS,  32'h0);
    expect_v("t2_idle_din", S_DIN, 32'h0);
    check_out();
    GPIOIN[3] = 1'b1;
    tick(LAT);
    expect_v("t2_is_pre", S_IS, 32'h0);
    check_out();
    tick(1);
    expect_v("t2_is_set",  S_IS,  32'h0008);
    expect_v("t2_irq_pre", S_IRQ, 32'h0);
    check_out();
    tick(1);
    expect_v("t2_irq_set", S_IRQ, 32'h1);
    expect_v("t2_is_hold", S_IS,  32'h0008);
    check_out();
    wif.WGPIOIC = 16'h0008;
    tick(1);
    wif.WGPIOIC = '0;
    expect_v("t2_is_clr",  S_IS,  32'h0);
    expect_v("t2_irq_lag", S_IRQ, 32'h1);
    check_out();
    tick(1);
    expect_v("t2_irq_clr", S_IRQ, 32'h0);
    check_out();

    // Pin 5 level-low: clear cannot stick while the level persists
    wif.WGPIOIE = 16'h0020;
    wif.WGPIOIT = '0;
    wif.WGPIOIP = '0;
    tick(1);
    expect_v("t3_is_set", S_IS, 32'h0020);
    check_out();
    tick(1);
    expect_v("t3_irq", S_IRQ, 32'h1);
    check_out();
    wif.WGPIOIC = 16'h0020;
    tick(1);
    wif.WGPIOIC = '0;
    expect_v("t3_reassert", S_IS, 32'h0020);
    check_out();
    GPIOIN[5] = 1'b1;
    tick(LAT);
    wif.WGPIOIC = 16'h0020;
    tick(1);
    wif.WGPIOIC = '0;
    expect_v("t3_is_clr", S_IS, 32'h0);
    check_out();
    tick(2);
    expect_v("t3_is_stay",  S_IS,  32'h0);
    expect_v("t3_irq_clr",  S_IRQ, 32'h0);
    expect_v("t3_din",      S_DIN, 32'h0028);
    check_out();

    // Pin 0 falling edge coincident with clear: set wins
    wif.WGPIOIE = 16'h0001;
    wif.WGPIOIT = 16'h0001;
    wif.WGPIOIP = '0;
    GPIOIN[0]   = 1'b1;
    tick(LAT + 2);
    expect_v("t4_rise_ignored", S_IS, 32'h0);
    check_out();
    GPIOIN[0] = 1'b0;
    tick(LAT);
    wif.WGPIOIC = 16'h0001;
    tick(1);
    wif.WGPIOIC = '0;
    expect_v("t4_set_wins", S_IS, 32'h0001);
    check_out();
    wif.WGPIOIC = 16'h0001;
    tick(1);
    wif.WGPIOIC = '0;
    expect_v("t4_clr", S_IS, 32'h0);
    check_out();

    // Masked edge, then pad passthrough within the same cycle
    wif.WGPIOIE = '0;
    wif.WGPIOIT = '1;
    wif.WGPIOIP = '1;
    GPIOIN[7]   = 1'b1;
    tick(LAT + 3);
    expect_v("t5_is_masked",  S_IS,  32'h0);
    expect_v("t5_irq_masked", S_IRQ, 32'h0);
    expect_v("t5_din",        S_DIN, 32'h00A8);
    check_out();
    wif.WGPIODOUT = 16'hA5A5;
    wif.WGPIODIR  = 16'h00FF;
    wif.WGPIOPU   = 16'h1234;
    wif.WGPIOPD   = 16'h4321;
    #1;
    expect_v("pad_out", S_OUT, 32'hA5A5);
    expect_v("pad_oen", S_OEN, 32'h00FF);
    expect_v("pad_pu",  S_PU,  32'h1234);
    expect_v("pad_pd",  S_PD,  32'h4321);
    check_out();

    // Status retained after IE is dropped; IRQ follows the mask
    wif.WGPIOIE = 16'h0100;
    GPIOIN[8]   = 1'b1;
    tick(LAT + 1);
    expect_v("t6_is_set", S_IS, 32'h0100);
    check_out();
    tick(1);
    expect_v("t6_irq", S_IRQ, 32'h1);
    check_out();
    wif.WGPIOIE = '0;
    tick(1);
    expect_v("t6_is_kept", S_IS,  32'h0100);
    expect_v("t6_irq_off", S_IRQ, 32'h0);
    check_out();
    wif.WGPIOIC = 16'h0100;
    tick(1);
    wif.WGPIOIC = '0;
    expect_v("t6_is_clr", S_IS, 32'h0);
    check_out();

`ifdef GPIO_DEBOUNCE_EN
    // Short bounce filtered out, long pulse accepted after DB cycles
    wif.WGPIOIE = 16'h0002;
    wif.WGPIOIT = 16'h0002;
    wif.WGPIOIP = 16'h0002;
    GPIOIN[1]   = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) GPIOIN[1] = 1'b0;
      tick(1);
      expect_v("db_short_din", S_DIN, 32'h01A8);
      check_out();
    end
    expect_v("db_short_is", S_IS, 32'h0);
    check_out();
    GPIOIN[1] = 1'b1;
    tick(LAT - 1);
    expect_v("db_long_pre", S_DIN, 32'h01A8);
    check_out();
    tick(1);
    expect_v("db_long_din", S_DIN, 32'h01AA);
    check_out();
    tick(1);
    expect_v("db_long_is", S_IS, 32'h0002);
    check_out();
    GPIOIN[1] = 1'b0;
    wif.WGPIOIC = 16'h0002;
    tick(1);
    wif.WGPIOIC = '0;
`endif

    // Asynchronous reset mid-operation and re-arming on release
    wif.WGPIOIE = 16'h0200;
    wif.WGPIOIT = '0;
    wif.WGPIOIP = 16'h0200;
    GPIOIN[9]   = 1'b1;
    tick(LAT + 2);
    expect_v("t7_irq_pre_rst", S_IRQ, 32'h1);
    check_out();
    #2;
    HRESET = 1'b1;
    #1;
    expect_v("t7_rst_din", S_DIN, 32'h0);
    expect_v("t7_rst_is",  S_IS,  32'h0);
    expect_v("t7_rst_irq", S_IRQ, 32'h0);
    check_out();
    tick(1);
    HRESET = 1'b0;
    tick(ARM);
    expect_v("t7_arm_hold", S_IS, 32'h0);
    check_out();
    tick(1);
    expect_v("t7_armed_is", S_IS, 32'h0200);
    check_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
